// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Contents:
//   uart_state_t    : receiver FSM state encoding
//   clog2()         : constant ceiling-log2, minimum result 1
//   UART_OVERSAMPLE : default tick pulses per bit, shared with baud_gen and uart_tx
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_OVERSAMPLE = 16;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for one asynchronous input
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset; both flops load RESET_VALUE
//   d   : asynchronous input
//   q   : synchronised output, two clk after d
module uart_sync2 #(
    parameter bit RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled 8N1-style UART receiver, LSB first
// Optional parity stage built when UART_RX_PARITY_EN is defined.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   tick       : one-clk enable, OVERSAMPLE pulses per bit time
//   rx         : asynchronous serial line, idle high
//   data_out   : last correctly framed word, held until the next good frame
//   data_valid : one-clk pulse when data_out updates
//   frame_err  : one-clk pulse when the stop bit samples low
//   busy       : high whenever the FSM is not IDLE
//   parity_err : (UART_RX_PARITY_EN only) one-clk pulse on a parity mismatch
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CW = clog2(OVERSAMPLE);
    localparam int IW = clog2(DATA_BITS);
    localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    uart_state_t          state_q, state_d;
    logic                 rx_s;
    logic                 armed;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 shift_en;
    logic                 stop_ok;
    logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 par_en;
`endif

    uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s && armed) state_d = START;
            end
            START: begin
                // Line back high at mid start bit is treated as a glitch.
                if (tick && cnt == MID_CNT) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick && cnt == LAST_CNT) begin
                    shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (idx == LAST_IDX) state_d = PARITY;
`else
                    if (idx == LAST_IDX) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && cnt == LAST_CNT) begin
                    par_en  = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid stop bit so a 1-bit stop allows back-to-back frames.
                if (tick && cnt == LAST_CNT) begin
                    state_d  = IDLE;
                    stop_ok  = rx_s;
                    stop_bad = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            armed      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (state_d != state_q || state_q == IDLE) cnt <= '0;
            else if (tick) cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;

            if (state_q != DATA) idx <= '0;
            else if (shift_en)   idx <= idx + 1'b1;

            // Line order is LSB first, so each new bit enters at the MSB.
            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

            // A break (line held low) must not re-trigger until the line idles high.
            if (stop_bad) armed <= 1'b0;
            else if (state_q == IDLE && rx_s) armed <= 1'b1;

            if (stop_ok) data_out <= shreg;
            data_valid <= stop_ok;
            frame_err  <= stop_bad;
`ifdef UART_RX_PARITY_EN
            if (par_en) par_bit <= rx_s;
            parity_err <= stop_ok && ((^shreg ^ par_bit) != PARITY_ODD);
`endif
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT_CLK = 64;  // 16 ticks x 4 clk per tick
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int ncmp = 0;
    int nfail = 0;
    int nvalid = 0;
    int nferr = 0;
    int nperr = 0;
    logic [7:0] vq[$];
    int v0, f0, p0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #10 clk = ~clk;

    initial begin : tick_gen
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (data_valid) begin
                nvalid = nvalid + 1;
                vq.push_back(data_out);
            end
            if (frame_err) nferr = nferr + 1;
`ifdef UART_RX_PARITY_EN
            if (parity_err) nperr = nperr + 1;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp = ncmp + 1;
        assert (obs === exp) else begin
            nfail = nfail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_raw(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par);
        send_bit(stop);
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_raw(d, ^d, 1'b1);
    endtask

    task automatic snap();
        v0 = nvalid;
        f0 = nferr;
        p0 = nperr;
        vq.delete();
    endtask

    initial begin
        logic [7:0] exp_b2b[3];
        exp_b2b[0] = 8'h00;
        exp_b2b[1] = 8'hFF;
        exp_b2b[2] = 8'h81;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);

        // Good frame 0xA5
        snap();
        send_frame(8'hA5);
        repeat (8) @(negedge clk);
        check("a5_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("a5_value", (vq.size() > 0) ? 32'(vq[0]) : 32'hDEAD, 32'hA5);
        check("a5_data_out", 32'(data_out), 32'hA5);
        check("a5_ferr_cnt", 32'(nferr - f0), 32'd0);
        check("a5_busy_after", 32'(busy), 32'h0);

        // Start-bit glitch of 3 ticks
        snap();
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_during", 32'(busy), 32'h1);
        repeat (2 * BIT_CLK) @(negedge clk);
        check("glitch_valid_cnt", 32'(nvalid - v0), 32'd0);
        check("glitch_ferr_cnt", 32'(nferr - f0), 32'd0);
        check("glitch_data_out", 32'(data_out), 32'hA5);
        check("glitch_busy_after", 32'(busy), 32'h0);

        // Bad stop on 0x3C followed by a 40-bit break
        snap();
        send_raw(8'h3C, ^8'h3C, 1'b0);
        repeat (40 * BIT_CLK) @(negedge clk);
        check("brk_ferr_cnt", 32'(nferr - f0), 32'd1);
        check("brk_valid_cnt", 32'(nvalid - v0), 32'd0);
        check("brk_data_out", 32'(data_out), 32'hA5);
        check("brk_busy_held_low", 32'(busy), 32'h0);
        send_bit(1'b1);
        send_bit(1'b1);
        snap();
        send_frame(8'h5A);
        repeat (8) @(negedge clk);
        check("post_brk_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("post_brk_data_out", 32'(data_out), 32'h5A);

        // Back-to-back frames, no idle gap
        snap();
        send_frame(8'h00);
        send_frame(8'hFF);
        send_frame(8'h81);
        repeat (8) @(negedge clk);
        check("b2b_valid_cnt", 32'(nvalid - v0), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_value%0d", i),
                  (vq.size() > i) ? 32'(vq[i]) : 32'hDEAD, 32'(exp_b2b[i]));
        check("b2b_ferr_cnt", 32'(nferr - f0), 32'd0);

        // Reset in the middle of data bit 4 of 0x77
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'((8'h77 >> i) & 8'h1));
        rx = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_data_out", 32'(data_out), 32'h0);
        check("rstmid_data_valid", 32'(data_valid), 32'h0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("rstmid_valid_cnt", 32'(nvalid - v0), 32'd0);
        check("rstmid_ferr_cnt", 32'(nferr - f0), 32'd0);
        snap();
        send_frame(8'h12);
        repeat (8) @(negedge clk);
        check("post_rst_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("post_rst_data_out", 32'(data_out), 32'h12);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        snap();
        send_raw(8'h07, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check("par_bad_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("par_bad_data_out", 32'(data_out), 32'h07);
        check("par_bad_perr_cnt", 32'(nperr - p0), 32'd1);
        snap();
        send_raw(8'h07, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        check("par_good_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("par_good_perr_cnt", 32'(nperr - p0), 32'd0);
        check("par_good_ferr_cnt", 32'(nferr - f0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1-style UART receiver, LSB first.
- Driven by the oversampled tick from baud_gen, built with OVERSAMPLE=16.
- Synchronises the asynchronous serial input and validates the start bit at mid-bit.
- Samples each data bit at its centre, checks the stop bit, and presents the received byte with a one-cycle valid strobe to downstream logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 16, tick pulses per bit period; must match baud_gen OVERSAMPLE; even, >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- tick  input  1  one-clk-wide enable pulse from baud_gen, OVERSAMPLE per bit time.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  last correctly framed word; held until the next good frame.
- data_valid  output  1  one-clk pulse when data_out updates.
- frame_err  output  1  one-clk pulse when the stop bit samples low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, async) puts every register in its idle condition:
  - FSM=IDLE; sync flops=1; counters=0.
  - data_out=0; data_valid=0; frame_err=0; busy=0.
- Synchroniser: rx passes through 2 flops; rx_s is the second flop. Input-to-rx_s latency is 2 clk.
- Tick counter: width clog2(OVERSAMPLE). Advances only on clk edges where tick=1. Cleared on every state entry.
- IDLE:
  - If rx_s=0 and armed=1: go to START, clear counter.
  - armed is set when rx_s=1 is seen in IDLE and cleared on a framing error. This prevents a held-low break line from re-triggering.
- START:
  - On the tick where count reaches OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - If 0: go to DATA, clear counter and bit index.
  - If 1 (glitch): return to IDLE; no outputs pulse.
- DATA:
  - On every tick where count = OVERSAMPLE-1: shift rx_s into the MSB of the shift register (LSB-first line order), wrap count to 0, increment bit index.
  - After DATA_BITS samples: go to STOP.
- STOP:
  - On the tick where count = OVERSAMPLE-1, sample rx_s.
  - If 1: data_out <= shift register; data_valid=1 for exactly one clk.
  - If 0: frame_err=1 for one clk; data_out unchanged; armed <= 0.
  - In both cases go to IDLE on the same edge. Returning at mid stop bit permits back-to-back frames with a 1-bit stop.
- data_valid and frame_err are registered, mutually exclusive, and never asserted outside the STOP exit edge.
- End-to-end latency: data_valid asserts at the clk edge of the mid-stop-bit tick, roughly (DATA_BITS+1.5) bit times after the start-bit falling edge, plus 2 clk of synchroniser delay.
- tick held high continuously is legal: the FSM then advances once per clk.
- rst asserted mid-frame: immediate abort to IDLE. No pulse on deassert; re-arm needs rx_s=1.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0 = even) is added.
  - Output parity_err (1, one-clk pulse) is added.
  - A PARITY state sits between DATA and STOP and samples one bit after OVERSAMPLE ticks.
  - A parity mismatch pulses parity_err on the STOP exit edge. data_out still updates and data_valid still pulses if the stop bit is good.
  - If the stop bit is bad, only frame_err pulses.
- When undefined: no parity state, no parity_err port; frame = start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg contains:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - a clog2 constant function;
  - a default OVERSAMPLE=16 constant, shared with baud_gen and the future uart_tx.
- One sub-module, uart_sync2: 2-flop synchroniser with async active-low reset, reset value parameterised (1 for rx).

Test Plan:
- Bench setup: clk 50 MHz; tick every 4 clk.
- Frame 0xA5, stop=1 -> one data_valid pulse; data_out=8'hA5; frame_err never high; busy low after the pulse.
- rx low for 3 ticks then high (glitch) -> FSM returns to IDLE at mid start bit; no data_valid; data_out unchanged.
- Frame 0x3C with stop=0, rx then held low 40 bit times -> exactly one frame_err pulse, data_out keeps its previous value, no retrigger until rx goes high. A following 0x5A frame is received correctly.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three data_valid pulses in order, values 00/FF/81.
- rst low in the middle of data bit 4 of 0x77 -> outputs 0 and busy 0 immediately; no pulse after release; next 0x12 received correctly.
- UART_RX_PARITY_EN, even parity: 0x07 with parity bit 0 -> data_valid with data_out=07 plus parity_err pulse. The same frame with parity bit 1 -> data_valid only.
